mem_wb_pipe_stage: RTL and testbench

//  Parametrised MEM->WB stage register. Replaces the fixed 70-bit always-load register.

---
 rtl/mem_wb_pipe_stage.sv | 214 +++++++++++++++++++++
 tb/tb_mem_wb_pipe_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_stage.sv
// rtl/mem_wb_pipe_stage.sv - MEM->WB pipeline stage register with handshake, flush, forwarding tap and stall counter
//
// Purpose:
//   Holds one memory-stage result between data-memory access and register-file
//   write-back. Upstream and downstream are decoupled by a valid/ready
//   handshake. A synchronous flush drops every held and incoming entry.
//   The write-back enable and the forwarding valid are gated by out_valid so
//   bubbles never write. A saturating counter records downstream stall cycles.
//
// Configuration macro:
//   MEM_WB_SKID_EN  undefined : single-entry stage, in_ready = !out_valid | out_ready
//                   defined   : two-entry skid buffer, in_ready is registered
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   flush              drop held and incoming entries this cycle
//   in_valid/in_ready  upstream handshake
//   in_wb_en           entry writes the register file
//   in_mem_r_en        entry is a load (write back memory data)
//   in_alu_res         ALU result
//   in_mem_data        data-memory read result
//   in_dest            destination register index
//   out_valid/out_ready downstream handshake
//   out_wb_en          stored wb_en gated by out_valid
//   out_mem_r_en       stored mem_r_en
//   out_alu_res        stored ALU result
//   out_mem_data       stored memory result
//   out_dest           stored destination
//   fwd_valid          out_valid & out_wb_en
//   fwd_dest           forwarding destination (= out_dest)
//   fwd_value          selected write-back value
//   stall_cnt          saturating count of out_valid & !out_ready cycles

module mem_wb_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_value,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_data;
    logic [DEST_W-1:0] dest;
  } entry_t;

  entry_t in_entry;
  entry_t main_q, main_d;
  logic   valid;
  logic   accept;
  logic   consume;

  assign in_entry.wb_en    = in_wb_en;
  assign in_entry.mem_r_en = in_mem_r_en;
  assign in_entry.alu_res  = in_alu_res;
  assign in_entry.mem_data = in_mem_data;
  assign in_entry.dest     = in_dest;

  // Flush wins over a simultaneous accept, so it is folded into accept itself.
  assign accept  = in_valid & in_ready & ~flush;
  assign consume = valid & out_ready;

`ifdef MEM_WB_SKID_EN

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t skid_q, skid_d;

  assign valid = (state_q != S_EMPTY);
  // Purely a function of registered state: no path from out_ready.
  assign in_ready = (state_q != S_TWO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Payload left untouched; only occupancy is dropped.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            main_d = in_entry;
          end else if (accept) begin
            // Downstream stalled: park the younger entry behind main.
            skid_d  = in_entry;
            state_d = S_TWO;
          end else if (consume) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

`else

  logic out_valid_q, out_valid_d;

  assign valid    = out_valid_q;
  assign in_ready = ~out_valid_q | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      main_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    main_d      = main_q;
    if (accept) begin
      main_d = in_entry;
    end
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      // Covers accept-with-consume: stays valid with the new payload.
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

`endif

  // Stall counter: saturating, reset only by rst, independent of flush.
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid    = valid;
  assign out_wb_en    = main_q.wb_en & valid;
  assign out_mem_r_en = main_q.mem_r_en;
  assign out_alu_res  = main_q.alu_res;
  assign out_mem_data = main_q.mem_data;
  assign out_dest     = main_q.dest;
  assign fwd_valid    = valid & main_q.wb_en;
  assign fwd_dest     = main_q.dest;
  assign fwd_value    = main_q.mem_r_en ? main_q.mem_data : main_q.alu_res;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// tb/tb_mem_wb_pipe_stage.sv - directed self-checking bench for mem_wb_pipe_stage
module tb_mem_wb_pipe_stage;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_wb_en = 1'b0;
  logic              in_mem_r_en = 1'b0;
  logic [DATA_W-1:0] in_alu_res = '0;
  logic [DATA_W-1:0] in_mem_data = '0;
  logic [DEST_W-1:0] in_dest = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_wb_en;
  logic              out_mem_r_en;
  logic [DATA_W-1:0] out_alu_res;
  logic [DATA_W-1:0] out_mem_data;
  logic [DEST_W-1:0] out_dest;
  logic              fwd_valid;
  logic [DEST_W-1:0] fwd_dest;
  logic [DATA_W-1:0] fwd_value;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  mem_wb_pipe_stage #(
    .DATA_W(DATA_W),
    .DEST_W(DEST_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wb_en    (in_wb_en),
    .in_mem_r_en (in_mem_r_en),
    .in_alu_res  (in_alu_res),
    .in_mem_data (in_mem_data),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wb_en   (out_wb_en),
    .out_mem_r_en(out_mem_r_en),
    .out_alu_res (out_alu_res),
    .out_mem_data(out_mem_data),
    .out_dest    (out_dest),
    .fwd_valid   (fwd_valid),
    .fwd_dest    (fwd_dest),
    .fwd_value   (fwd_value),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic mr,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                       input logic [DEST_W-1:0] dst);
    in_valid    = v;
    in_wb_en    = wb;
    in_mem_r_en = mr;
    in_alu_res  = alu;
    in_mem_data = mem;
    in_dest     = dst;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_wb_en, out_mem_r_en, fwd_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {out_valid, out_wb_en, out_mem_r_en, fwd_valid});
    end
    checks++;
    if ({out_alu_res, out_mem_data, fwd_value} !== '0) begin
      errors++;
      $display("FAIL reset_data: got alu=%0h mem=%0h fwd=%0h expected 0", out_alu_res, out_mem_data, fwd_value);
    end
    checks++;
    if ({out_dest, fwd_dest, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_dest_cnt: got dest=%0h fwd_dest=%0h cnt=%0d expected 0", out_dest, fwd_dest, stall_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_load();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h11, 32'hABCD, 4'd5);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    checks++;
    if ({out_valid, fwd_valid, out_wb_en} !== 3'b111) begin
      errors++;
      $display("FAIL load_valids: got %b expected 111", {out_valid, fwd_valid, out_wb_en});
    end
    checks++;
    if (fwd_dest !== 4'd5) begin
      errors++;
      $display("FAIL load_fwd_dest: got %0d expected 5", fwd_dest);
    end
    checks++;
    if (fwd_value !== 32'hABCD) begin
      errors++;
      $display("FAIL load_fwd_value: got %0h expected abcd", fwd_value);
    end
    checks++;
    if (out_alu_res !== 32'h11) begin
      errors++;
      $display("FAIL load_alu_res: got %0h expected 11", out_alu_res);
    end
    step();
    checks++;
    if ({out_valid, out_wb_en, fwd_valid} !== 3'b000) begin
      errors++;
      $display("FAIL load_drain_bubble: got %b expected 000", {out_valid, out_wb_en, fwd_valid});
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, DATA_W'(i), 32'hFFFF, DEST_W'(i));
      step();
      checks++;
      if (out_valid !== 1'b1 || fwd_value !== DATA_W'(i)) begin
        errors++;
        $display("FAIL b2b_entry%0d: got valid=%b value=%0h expected valid=1 value=%0h", i, out_valid, fwd_value, i);
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got %b expected 0", out_valid);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL b2b_stall_cnt: got %0d expected 0", stall_cnt);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hA1, 32'h0, 4'd1);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'hB2, 32'h0, 4'd2);
    for (int c = 1; c <= 3; c++) begin
      step();
`ifdef MEM_WB_SKID_EN
      in_valid = 1'b0;
`endif
      checks++;
      if (out_valid !== 1'b1 || out_alu_res !== 32'hA1) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b alu=%0h expected valid=1 alu=a1", c, out_valid, out_alu_res);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready%0d: got %b expected 0", c, in_ready);
      end
    end
    checks++;
    if (stall_cnt !== 4'd3) begin
      errors++;
      $display("FAIL stall_cnt3: got %0d expected 3", stall_cnt);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_alu_res !== 32'hB2) begin
      errors++;
      $display("FAIL stall_order: got valid=%b alu=%0h expected valid=1 alu=b2", out_valid, out_alu_res);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd3) begin
      errors++;
      $display("FAIL stall_drain: got valid=%b cnt=%0d expected valid=0 cnt=3", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'hD4, 32'h0, 4'd4);
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    checks++;
    if ({out_valid, out_wb_en, fwd_valid} !== 3'b000) begin
      errors++;
      $display("FAIL flush_empty: got %b expected 000", {out_valid, out_wb_en, fwd_valid});
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_never_out: got %b expected 0", out_valid);
    end
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hC3, 32'h0, 4'd3);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_alu_res !== 32'hC3) begin
      errors++;
      $display("FAIL flush_preload: got valid=%b alu=%0h expected valid=1 alu=c3", out_valid, out_alu_res);
    end
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'hE5, 32'h0, 4'd6);
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    checks++;
    if ({out_valid, out_wb_en, fwd_valid} !== 3'b000) begin
      errors++;
      $display("FAIL flush_held: got %b expected 000", {out_valid, out_wb_en, fwd_valid});
    end
    checks++;
    if (out_alu_res !== 32'hC3) begin
      errors++;
      $display("FAIL flush_payload_kept: got %0h expected c3", out_alu_res);
    end
    checks++;
    if (stall_cnt !== 4'd4) begin
      errors++;
      $display("FAIL flush_stall_cnt: got %0d expected 4", stall_cnt);
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_reset_pre: got %0d expected 0", stall_cnt);
    end
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 4'd7);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 14) begin
        checks++;
        if (stall_cnt !== 4'd14) begin
          errors++;
          $display("FAIL sat_cnt14: got %0d expected 14", stall_cnt);
        end
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_cnt15: got %0d expected 15", stall_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (stall_cnt !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_reset_post: got cnt=%0d valid=%b expected cnt=0 valid=0", stall_cnt, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_flush();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
